// File: rtl/invert_serial.sv
// invert_serial
// ---------------------------------------------------------------------------
// Bit-serial two's-complement negator. The operand arrives one bit per clock,
// LSB first, and the negated result leaves on the same cycle, also LSB first.
// It uses the copy-until-first-one rule: result bits equal operand bits up to
// and including the first 1, and every later bit is inverted.
//
// Ports
//   i      in   serial operand bit, LSB first, one bit per t_clk cycle
//   r      in   asynchronous active-high reset; also marks the start of a word
//   t_clk  in   clock, state updates on the rising edge only
//   y      out  serial result bit, valid in the same cycle as its operand bit
// ---------------------------------------------------------------------------
module invert_serial (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);

  // COPY until the first 1 has gone past, INVERT from then on.
  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } seen_t;

  seen_t seen_q;
  seen_t seen_d;

  // State register. Reset is asynchronous so a new word can be started
  // between edges; edges that occur while r is high are ignored.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      seen_q <= COPY;
    end else begin
      seen_q <= seen_d;
    end
  end

  // Next-state and Mealy output. The first 1 is still copied because the
  // state only changes at the following edge, which is why y depends on
  // the current state rather than the next one.
  always_comb begin
    seen_d = seen_q;
    y      = i;
    case (seen_q)
      COPY: begin
        y = i;
        if (i) begin
          seen_d = INVERT;
        end
      end
      INVERT: begin
        y = ~i;
      end
      default: begin
        seen_d = COPY;
        y      = i;
      end
    endcase
  end

endmodule

// File: tb/tb_invert_serial.sv
// tb_invert_serial
// ---------------------------------------------------------------------------
// Self-checking bench for invert_serial. Every driven bit pushes its expected
// result onto a scoreboard queue; the result is popped and compared when y is
// sampled at the falling edge (or between edges for combinational checks).
// ---------------------------------------------------------------------------
module tb_invert_serial;

  logic i;
  logic r;
  logic t_clk;
  logic y;

  int assertCount;
  int failCount;

  string tagQ[$];
  logic  expQ[$];

  invert_serial dut (
    .i     (i),
    .r     (r),
    .t_clk (t_clk),
    .y     (y)
  );

  initial begin
    t_clk = 1'b0;
    forever #5 t_clk = ~t_clk;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, required %b", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input string tag, input logic exp);
    tagQ.push_back(tag);
    expQ.push_back(exp);
  endtask

  task automatic popCheck();
    string tag;
    logic  exp;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      tag = tagQ.pop_front();
      exp = expQ.pop_front();
      checkOutput(tag, y, exp);
    end
  endtask

  // Drive one serial bit just after a rising edge and check y at the
  // falling edge, before the next rising edge samples the bit.
  task automatic applyStimulus(input logic bitIn, input logic expY, input string tag);
    @(posedge t_clk);
    #1;
    i = bitIn;
    pushExpect(tag, expY);
    @(negedge t_clk);
    popCheck();
  endtask

  // Pulse reset between edges. While r is high y must follow i. The operand
  // is parked at 0 before r drops so no stray 1 is recorded.
  task automatic doReset(input string tag);
    @(posedge t_clk);
    #1;
    r = 1'b1;
    i = 1'b1;
    #1;
    pushExpect({tag, "_rst_i1"}, 1'b1);
    popCheck();
    i = 1'b0;
    #1;
    pushExpect({tag, "_rst_i0"}, 1'b0);
    popCheck();
    r = 1'b0;
  endtask

  // Reset, then stream an n-bit word LSB first and compare each output bit
  // with the arithmetic negation (2^n - word) mod 2^n.
  task automatic streamWord(input int word, input int n, input string tag);
    int modulus;
    int negated;
    modulus = 1 << n;
    negated = (modulus - word) % modulus;
    doReset(tag);
    for (int b = 0; b < n; b++) begin
      applyStimulus(logic'((word >> b) & 1), logic'((negated >> b) & 1),
                    $sformatf("%s_b%0d", tag, b));
    end
  endtask

  initial begin
    int w;
    assertCount = 0;
    failCount   = 0;
    i = 1'b0;
    r = 1'b0;

    // Word 6 over 4 bits -> 0,1,0,1 (10).
    streamWord(6, 4, "word6");

    // All-zero word, then continue without reset: 1,0,1 -> 1,1,0.
    doReset("zeros");
    applyStimulus(1'b0, 1'b0, "zeros_b0");
    applyStimulus(1'b0, 1'b0, "zeros_b1");
    applyStimulus(1'b0, 1'b0, "zeros_b2");
    applyStimulus(1'b0, 1'b0, "zeros_b3");
    applyStimulus(1'b1, 1'b1, "cont_b0");
    applyStimulus(1'b0, 1'b1, "cont_b1");
    applyStimulus(1'b1, 1'b0, "cont_b2");

    // Reset held high with i=1 across three rising edges: nothing recorded.
    @(posedge t_clk);
    #1;
    r = 1'b1;
    i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pushExpect($sformatf("rsthold_%0d", k), 1'b1);
      @(negedge t_clk);
      popCheck();
      @(posedge t_clk);
    end
    #1;
    r = 1'b0;
    pushExpect("rstdrop_first1", 1'b1);
    @(negedge t_clk);
    popCheck();
    applyStimulus(1'b1, 1'b0, "rstdrop_second1");

    // Mid-word asynchronous reset: enter INVERT, then raise r between edges.
    doReset("async");
    applyStimulus(1'b1, 1'b1, "async_b0");
    applyStimulus(1'b0, 1'b1, "async_b1");
    #1;
    r = 1'b1;
    #1;
    pushExpect("async_drop", 1'b0);
    popCheck();
    r = 1'b0;
    applyStimulus(1'b0, 1'b0, "async_after0");
    applyStimulus(1'b1, 1'b1, "async_after1");

    // Boundary words.
    streamWord(1, 4, "word1");
    streamWord(8, 4, "word8");
    streamWord(0, 8, "word0");
    streamWord(128, 8, "word128");

    // In INVERT, y follows ~i combinationally as i toggles between edges.
    doReset("toggle");
    applyStimulus(1'b1, 1'b1, "toggle_first1");
    @(posedge t_clk);
    #1;
    i = 1'b0;
    #1;
    pushExpect("toggle_i0", 1'b1);
    popCheck();
    i = 1'b1;
    #1;
    pushExpect("toggle_i1", 1'b0);
    popCheck();
    i = 1'b0;
    #1;
    pushExpect("toggle_i0b", 1'b1);
    popCheck();
    applyStimulus(1'b0, 1'b1, "toggle_stay0");
    applyStimulus(1'b1, 1'b0, "toggle_stay1");

    // A few random 8-bit words.
    for (int k = 0; k < 4; k++) begin
      w = int'($urandom_range(0, 255));
      streamWord(w, 8, $sformatf("rand%0d", k));
    end

    if (expQ.size() != 0) begin
      checkOutput("scoreboard_leftover", 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
